// File: rtl/run_event_queue.sv
// Timestamped event queue fed by a run detector: stamps each qualifying d pulse, queues it
// in a show-ahead FIFO, and tracks a saturating event count and sticky overflow.
// Optional: define RUN_EVENT_EDGE_ONLY_EN to emit one event per contiguous high run of d.
module run_event_queue #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             ovf_clr,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [TS_W-1:0]  ev_time,
  output logic [CNT_W-1:0] ev_count,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      OCC_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      OCC_MAX = (AW+1)'(DEPTH);

  logic [TS_W-1:0]             ts;
  logic [AW-1:0]               wptr, rptr;
  logic [AW:0]                 occ;
  logic [DEPTH-1:0][TS_W-1:0]  mem;
  logic                        ev, pop, push, drop;

`ifdef RUN_EVENT_EDGE_ONLY_EN
  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign ev = d & ~d_q;
`else
  assign ev = d;
`endif

  assign ev_valid = (occ != '0);
  assign full     = (occ == OCC_MAX);
  assign ev_time  = ev_valid ? mem[rptr] : '0;

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign pop  = ev_valid & ev_ready;
  assign push = ev & (~full | pop);
  assign drop = ev & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      mem      <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + TS_ONE;
      if (push) begin
        mem[wptr] <= ts;
        wptr      <= wptr + PTR_ONE;
      end
      if (pop) rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
      if (ev && ev_count != '1) ev_count <= ev_count + CNT_ONE;
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_run_event_queue.sv
// Bench for run_event_queue: a default-size instance and a TS_W=4/CNT_W=2 instance share
// stimulus and are checked against a queue-based reference model.
module tb_run_event_queue;
  localparam int DEPTH = 4;

  logic clk, reset, d, ovf_clr, ev_ready;
  logic        v0, f0, o0, v1, f1, o1;
  logic [15:0] t0;
  logic [7:0]  c0;
  logic [3:0]  t1;
  logic [1:0]  c1;

  int nchk = 0, nerr = 0;

  run_event_queue #(.TS_W(16), .DEPTH(DEPTH), .CNT_W(8)) u_big (
    .clk(clk), .reset(reset), .d(d), .ovf_clr(ovf_clr), .ev_ready(ev_ready),
    .ev_valid(v0), .ev_time(t0), .ev_count(c0), .full(f0), .overflow(o0));

  run_event_queue #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .d(d), .ovf_clr(ovf_clr), .ev_ready(ev_ready),
    .ev_valid(v1), .ev_time(t1), .ev_count(c1), .full(f1), .overflow(o1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        a_v[2], a_f[2], a_o[2];
  logic [15:0] a_t[2];
  logic [7:0]  a_c[2];
  assign a_v[0] = v0;  assign a_v[1] = v1;
  assign a_f[0] = f0;  assign a_f[1] = f1;
  assign a_o[0] = o0;  assign a_o[1] = o1;
  assign a_t[0] = t0;  assign a_t[1] = {12'b0, t1};
  assign a_c[0] = c0;  assign a_c[1] = {6'b0, c1};

  // Reference model: a queue of stamps plus counters, one set per instance.
  int m_ts[2], m_cnt[2];
  bit m_ovf[2], m_dq[2];
  int mq[2][$];

  function automatic int tsmod(input int i);
    return (i == 0) ? 65536 : 16;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_ts[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_dq[i] = 0;
      mq[i].delete();
    end
  endtask

  task automatic model_step(input int i);
    bit ev, drop;
`ifdef RUN_EVENT_EDGE_ONLY_EN
    ev = d && !m_dq[i];
`else
    ev = d;
`endif
    drop = 0;
    if (ev_ready && mq[i].size() != 0) void'(mq[i].pop_front());
    if (ev) begin
      if (m_cnt[i] < cmax(i)) m_cnt[i]++;
      if (mq[i].size() < DEPTH) mq[i].push_back(m_ts[i]);
      else drop = 1;
    end
    if (drop)         m_ovf[i] = 1;
    else if (ovf_clr) m_ovf[i] = 0;
    m_ts[i] = (m_ts[i] + 1) % tsmod(i);
    m_dq[i] = d;
  endtask

  // Drive at the falling edge, advance the model at the rising edge, return at the next fall.
  task automatic cyc(input logic dd, input logic rr, input logic cc);
    d = dd; ev_ready = rr; ovf_clr = cc;
    @(posedge clk);
    if (!reset) model_clear();
    else for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    d = 0; ev_ready = 0; ovf_clr = 0;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_ts(input int i, input int target);
    int n = 0;
    while (m_ts[i] != target && n < 100) begin
      cyc(0, 0, 0);
      n++;
    end
    nchk++;
    if (m_ts[i] != target) begin
      nerr++;
      $display("FAIL wait_ts: got ts %0d, expected %0d", m_ts[i], target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; d = 1; ev_ready = 1; ovf_clr = 0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nchk++;
      if ({v0, f0, o0, t0, c0, v1, f1, o1, t1, c1} !== '0) begin
        nerr++;
        $display("FAIL reset_hold: got outputs %h, expected 0",
                 {v0, f0, o0, t0, c0, v1, f1, o1, t1, c1});
      end
    end
    reset = 1'b1;
    cyc(1, 0, 0);
    nchk++;
    if (v0 !== 1'b1 || t0 !== 16'd0 || c0 !== 8'd1) begin
      nerr++;
      $display("FAIL reset_first_stamp: got v=%0b t=%0d c=%0d, expected v=1 t=0 c=1", v0, t0, c0);
    end
  endtask

  task automatic test_single();
    do_reset();
    wait_ts(0, 10);
    cyc(1, 0, 0);
    nchk++;
    if (v0 !== 1'b1 || t0 !== 16'd10 || c0 !== 8'd1) begin
      nerr++;
      $display("FAIL single_push: got v=%0b t=%0d c=%0d, expected v=1 t=10 c=1", v0, t0, c0);
    end
    cyc(0, 1, 0);
    nchk++;
    if (v0 !== 1'b0 || t0 !== 16'd0) begin
      nerr++;
      $display("FAIL single_pop: got v=%0b t=%0d, expected v=0 t=0", v0, t0);
    end
    cyc(0, 1, 0);
    nchk++;
    if (v0 !== 1'b0 || c0 !== 8'd1) begin
      nerr++;
      $display("FAIL ready_when_empty: got v=%0b c=%0d, expected v=0 c=1", v0, c0);
    end
  endtask

  task automatic test_run();
    do_reset();
    wait_ts(0, 20);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
`ifdef RUN_EVENT_EDGE_ONLY_EN
    nchk++;
    if (c0 !== 8'd1 || t0 !== 16'd20) begin
      nerr++;
      $display("FAIL run_edge: got c=%0d t=%0d, expected c=1 t=20", c0, t0);
    end
    cyc(0, 1, 0);
`else
    nchk++;
    if (c0 !== 8'd3) begin
      nerr++;
      $display("FAIL run_count: got %0d, expected 3", c0);
    end
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (t0 !== 16'(20 + k)) begin
        nerr++;
        $display("FAIL run_entry%0d: got %0d, expected %0d", k, t0, 20 + k);
      end
      cyc(0, 1, 0);
    end
`endif
    nchk++;
    if (v0 !== 1'b0) begin
      nerr++;
      $display("FAIL run_drained: got v=%0b, expected 0", v0);
    end
  endtask

  task automatic test_overflow();
    int st[5];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      st[k] = m_ts[0];
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    nchk++;
    if (f0 !== 1'b1 || o0 !== 1'b1 || c0 !== 8'd5) begin
      nerr++;
      $display("FAIL ovf_set: got full=%0b ovf=%0b c=%0d, expected 1 1 5", f0, o0, c0);
    end
    cyc(0, 0, 1);
    nchk++;
    if (o0 !== 1'b0 || f0 !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_clr: got ovf=%0b full=%0b, expected 0 1", o0, f0);
    end
    cyc(1, 0, 1);
    nchk++;
    if (o0 !== 1'b1 || c0 !== 8'd6) begin
      nerr++;
      $display("FAIL ovf_set_wins: got ovf=%0b c=%0d, expected 1 6", o0, c0);
    end
    cyc(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (t0 !== 16'(st[k])) begin
        nerr++;
        $display("FAIL ovf_entry%0d: got %0d, expected %0d", k, t0, st[k]);
      end
      cyc(0, 1, 0);
    end
  endtask

  task automatic test_full_push_pop();
    int st[4];
    int snew;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      st[k] = m_ts[0];
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    snew = m_ts[0];
    cyc(1, 1, 0);
    nchk++;
    if (o0 !== 1'b0 || f0 !== 1'b1 || t0 !== 16'(st[1])) begin
      nerr++;
      $display("FAIL full_push_pop: got ovf=%0b full=%0b t=%0d, expected 0 1 %0d", o0, f0, t0, st[1]);
    end
    for (int k = 1; k < 4; k++) cyc(0, 1, 0);
    nchk++;
    if (t0 !== 16'(snew) || v0 !== 1'b1) begin
      nerr++;
      $display("FAIL full_tail: got v=%0b t=%0d, expected v=1 t=%0d", v0, t0, snew);
    end
    cyc(0, 1, 0);
  endtask

  task automatic test_wrap_sat();
    int second;
    do_reset();
    wait_ts(1, 15);
    cyc(1, 0, 0);
`ifdef RUN_EVENT_EDGE_ONLY_EN
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    second = 1;
`else
    cyc(1, 0, 0);
    second = 0;
`endif
    nchk++;
    if (t1 !== 4'd15) begin
      nerr++;
      $display("FAIL wrap_first: got %0d, expected 15", t1);
    end
    cyc(0, 1, 0);
    nchk++;
    if (t1 !== 4'(second)) begin
      nerr++;
      $display("FAIL wrap_second: got %0d, expected %0d", t1, second);
    end
    repeat (3) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    nchk++;
    if (c1 !== 2'd3 || v1 !== 1'b1) begin
      nerr++;
      $display("FAIL sat_count: got c=%0d v=%0b, expected c=3 v=1", c1, v1);
    end
    #2 reset = 1'b0;
    #1;
    nchk++;
    if (v1 !== 1'b0 || f1 !== 1'b0 || t1 !== 4'd0 || c1 !== 2'd0 || v0 !== 1'b0) begin
      nerr++;
      $display("FAIL midstream_reset: got v1=%0b f1=%0b t1=%0d c1=%0d v0=%0b, expected all 0",
               v1, f1, t1, c1, v0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic rd, rr, rc;
    bit ev_v;
    int ev_t;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        rd = ($urandom_range(0, 99) < 45);
        rr = ($urandom_range(0, 99) < 35);
        rc = ($urandom_range(0, 99) < 5);
        cyc(rd, rr, rc);
      end
      for (int i = 0; i < 2; i++) begin
        ev_v = (mq[i].size() != 0);
        ev_t = ev_v ? mq[i][0] : 0;
        nchk++;
        if (a_v[i] !== ev_v || a_t[i] !== 16'(ev_t) || a_c[i] !== 8'(m_cnt[i]) ||
            a_f[i] !== (mq[i].size() == DEPTH) || a_o[i] !== m_ovf[i]) begin
          nerr++;
          $display("FAIL random dut%0d cyc%0d: got v=%0b t=%0d c=%0d f=%0b o=%0b, expected v=%0b t=%0d c=%0d f=%0b o=%0b",
                   i, n, a_v[i], a_t[i], a_c[i], a_f[i], a_o[i],
                   ev_v, ev_t, m_cnt[i], (mq[i].size() == DEPTH), m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; d = 0; ev_ready = 0; ovf_clr = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single();
    test_run();
    test_overflow();
    test_full_push_pop();
    test_wrap_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/run_event_queue.md
# run_event_queue

Downstream consumer of the three-consecutive-1s Mealy detector output `d`. Each qualifying detection is stamped with a free-running cycle timestamp and queued in a small show-ahead FIFO. Software or a later stage drains the FIFO over a valid/ready handshake. The block also keeps a saturating total-event count and a sticky overflow flag.

## Interface
- `TS_W`, 16: timestamp width; timestamp counter wraps modulo 2^TS_W.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the saturating event counter.
- `clk`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; `reset==0` immediately clears all state.
- `d`  in  1  detection pulse from the upstream detector, synchronous to `clk`.
- `ovf_clr`  in  1  synchronous clear of `overflow`.
- `ev_ready`  in  1  consumer accepts the head entry.
- `ev_valid`  out  1  FIFO non-empty; head entry is presented.
- `ev_time`  out  TS_W  timestamp of the head entry; 0 when empty.
- `ev_count`  out  CNT_W  total events detected since reset, saturating.
- `full`  out  1  FIFO holds DEPTH entries.
- `overflow`  out  1  sticky; set when an event was dropped.

## Operation
- Reset values: `ev_valid`=0, `ev_time`=0, `ev_count`=0, `full`=0, `overflow`=0. Timestamp counter, pointers, and occupancy are 0. The edge register (see Configuration) is 0.
- Timestamp counter `ts` increments by 1 every clock after reset and wraps from 2^TS_W−1 to 0.
- Event: `d` sampled high at a rising edge, subject to the Configuration qualification. The pushed value is `ts` as held before that edge's increment.
- Push rules:
  - If not full, the timestamp is written at the tail.
  - If full and a pop occurs on the same edge, the push is accepted. Occupancy stays at DEPTH.
  - If full with no pop, the event is dropped and `overflow` is set.
- Pop: `ev_valid && ev_ready` at a rising edge removes the head entry. `ev_ready` while empty has no effect.
- Push and pop on the same edge with the FIFO non-empty: both take effect and occupancy is unchanged. When the FIFO is empty, only the push takes effect.
- `ev_count` increments on every event, whether accepted or dropped. It holds at 2^CNT_W−1.
- `overflow` is cleared by `ovf_clr`. If `ovf_clr` and a drop occur on the same edge, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits. `full` = (occupancy==DEPTH). `ev_valid` = (occupancy≠0).
- Reset asserted mid-operation discards all queued entries immediately. The first edge after deassertion behaves as the first edge after power-up.

## Timing
- All outputs are registered or decoded from registers only; there is no combinational path from `d`, `ev_ready` or `ovf_clr` to any output.
- Push latency: an event sampled at edge N is reflected in `ev_valid`/`ev_time` after edge N, when the FIFO was empty. It is also reflected in `ev_count` after edge N.
- Pop latency: after a pop at edge N, the next entry or `ev_valid`=0 is presented after edge N.
- Throughput: one push and one pop per cycle.

## Configuration
- `RUN_EVENT_EDGE_ONLY_EN` defined:
  - A registered copy `d_q` of `d` is kept.
  - An event is `d && !d_q`, so one event is generated per contiguous high run of `d`.
  - With an overlapping detector, this gives one event per run of ≥3 ones.
- `RUN_EVENT_EDGE_ONLY_EN` undefined:
  - Every cycle with `d==1` is an event.
  - A run of k≥3 ones yields k−2 events.

## Test plan
- Reset check: hold `reset`=0, toggle `clk`, drive `d`=1 and `ev_ready`=1 → all outputs stay 0; release `reset` → `ts` counts from 0.
- Single detection: `d`=1 for one cycle at `ts`=10, `ev_ready`=0 → `ev_valid`=1, `ev_time`=10, `ev_count`=1. Raise `ev_ready` for one cycle → `ev_valid`=0.
- Run qualification: `d` high for 3 consecutive cycles at `ts`=20..22.
  - Macro undefined → 3 entries 20, 21, 22, `ev_count`=3.
  - Macro defined → 1 entry 20, `ev_count`=1.
- Overflow: `ev_ready`=0, 5 single-cycle events with DEPTH=4 → `full`=1, `overflow`=1, `ev_count`=5, FIFO holds the first 4 stamps. `ovf_clr` → `overflow`=0.
- Full with simultaneous push/pop: FIFO full, `d`=1 and `ev_ready`=1 on the same edge → `overflow` stays 0, occupancy stays 4, oldest stamp removed, new stamp at tail.
- Wrap and saturation: TS_W=4, CNT_W=2.
  - Event at `ts`=15, then an event at the next edge → stamps 15, 0.
  - 5 events total → `ev_count`=3.
  - Assert `reset` mid-stream → FIFO empty immediately.
